// File: rtl/adma_wb_mem_slave.sv
// adma_wb_mem_slave
// 64-bit Wishbone responder backed by on-chip RAM. It sits on the ADMA
// engine's master port and holds descriptors and data buffers.
// Each beat has the low word on dat and the high word on dat64.
//
// Parameters
//   AW          log2 of RAM depth in 64-bit words
//   WAIT_STATES idle cycles before the first ack of a cycle (0..15)
//   BASE        byte base address of the RAM window (bits [AW+2:0] zero)
//
// Ports
//   wb_clk_i, wb_rst_i        clock, synchronous active-high reset
//   wbs_cyc_i/stb_i/we_i      Wishbone cycle, strobe, write enable
//   wbs_cab_i                 consecutive-address burst
//   wbs_adr_i                 byte address (64-bit aligned)
//   wbs_sel_i                 byte enables, [3:0] dat, [7:4] dat64
//   wbs_dat_i/wbs_dat64_i     write data low/high word
//   wbs_dat_o/wbs_dat64_o     read data low/high word
//   wbs_ack_o/err_o/rty_o     beat acknowledge, error, retry
//   mem_busy_i                RAM owned elsewhere; new requests get retry
//   beat_cnt_o                acked beats in the current cycle
module adma_wb_mem_slave #(
    parameter int          AW          = 10,
    parameter int          WAIT_STATES = 2,
    parameter logic [31:0] BASE        = 32'h0
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic        wbs_cab_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [7:0]  wbs_sel_i,
    input  logic [31:0] wbs_dat_i,
    input  logic [31:0] wbs_dat64_i,
    output logic [31:0] wbs_dat_o,
    output logic [31:0] wbs_dat64_o,
    output logic        wbs_ack_o,
    output logic        wbs_err_o,
    output logic        wbs_rty_o,
    input  logic        mem_busy_i,
    output logic [15:0] beat_cnt_o
);

    localparam int         DEPTH     = 1 << AW;
    localparam logic [3:0] WAIT_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_ACK,
        S_TERM,
        S_GAP
    } state_e;

    state_e          state_q, state_d;
    logic [3:0]      wait_cnt_q, wait_cnt_d;
    logic            term_err_q, term_err_d;   // 1: TERM answers err, 0: rty
    logic [AW-1:0]   idx_q;                    // word index of the beat in ACK
    logic [15:0]     beat_cnt_q;

    logic            req;
    logic            beat_start;               // next cycle is an ACK beat
    logic [32:0]     cur_adr;
    logic [32:0]     nxt_adr;
    logic [32:0]     beat_adr;
    logic [AW-1:0]   rd_idx;
    logic            rd_en;
    logic            wr_en;
    logic [63:0]     wr_data;
    logic [63:0]     rd_data;

    // Legal when 64-bit aligned and inside the window. Addresses carry a
    // 33rd bit so that a burst stepping past 2^32 can never alias back in.
    function automatic logic addr_ok(input logic [32:0] a);
        logic [32:0] off;
        off     = a - {1'b0, BASE};
        addr_ok = (a[2:0] == 3'b000) && (a >= {1'b0, BASE}) && (off[32:AW+3] == '0);
    endfunction

    assign req     = wbs_cyc_i & wbs_stb_i;
    assign cur_adr = {1'b0, wbs_adr_i};
    // Bursts are linear, so the next beat address is predicted during the
    // current ack; that is what allows a registered read with zero wait.
    assign nxt_adr = cur_adr + 33'd8;

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        term_err_d = term_err_q;
        beat_start = 1'b0;
        beat_adr   = cur_adr;
        unique case (state_q)
            S_IDLE: begin
                if (req) begin
                    if (!addr_ok(cur_adr)) begin
                        state_d    = S_TERM;
                        term_err_d = 1'b1;
                    end else if (mem_busy_i) begin
                        state_d    = S_TERM;
                        term_err_d = 1'b0;
                    end else if (WAIT_STATES == 0) begin
                        state_d    = S_ACK;
                        beat_start = 1'b1;
                    end else begin
                        state_d    = S_WAIT;
                        wait_cnt_d = WAIT_LOAD;
                    end
                end
            end
            S_WAIT: begin
                if (!req) begin
                    state_d = S_IDLE;
                end else if (wait_cnt_q == 4'd0) begin
                    state_d    = S_ACK;
                    beat_start = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end
            end
            S_ACK: begin
                if (req && wbs_cab_i) begin
                    if (!addr_ok(nxt_adr)) begin
                        state_d    = S_TERM;
                        term_err_d = 1'b1;
                    end else begin
                        state_d    = S_ACK;
                        beat_start = 1'b1;
                        beat_adr   = nxt_adr;
                    end
                end else if (req) begin
                    state_d = S_GAP;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_TERM:  state_d = S_GAP;
            S_GAP:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q    <= S_IDLE;
            wait_cnt_q <= 4'd0;
            term_err_q <= 1'b0;
            idx_q      <= '0;
            beat_cnt_q <= 16'd0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            term_err_q <= term_err_d;
            if (beat_start) begin
                idx_q <= rd_idx;
            end
            if (!wbs_cyc_i) begin
                beat_cnt_q <= 16'd0;
            end else if (state_q == S_ACK && beat_cnt_q != 16'hFFFF) begin
                beat_cnt_q <= beat_cnt_q + 16'd1;
            end
        end
    end

    assign rd_idx  = beat_adr[AW+2:3];
    assign rd_en   = beat_start & ~wbs_we_i;
    // Writes land at the edge closing the ack cycle, so an aborted or reset
    // access never reaches the array.
    assign wr_en   = (state_q == S_ACK) & req & wbs_we_i;
    assign wr_data = {wbs_dat64_i, wbs_dat_i};

    // One byte-wide array per lane keeps byte enables a plain per-lane write.
    for (genvar gi = 0; gi < 8; gi++) begin : g_lane
        logic [7:0] mem_q [0:DEPTH-1];
        logic [7:0] rd_q;

        always_ff @(posedge wb_clk_i) begin
            if (wr_en && wbs_sel_i[gi]) begin
                mem_q[idx_q] <= wr_data[gi*8 +: 8];
            end
        end

        always_ff @(posedge wb_clk_i) begin
            if (wb_rst_i) begin
                rd_q <= 8'd0;
            end else if (rd_en) begin
                rd_q <= mem_q[rd_idx];
            end
        end

        assign rd_data[gi*8 +: 8] = rd_q;
    end

    assign wbs_dat_o   = rd_data[31:0];
    assign wbs_dat64_o = rd_data[63:32];
    assign wbs_ack_o   = (state_q == S_ACK);
    assign wbs_err_o   = (state_q == S_TERM) &  term_err_q;
    assign wbs_rty_o   = (state_q == S_TERM) & ~term_err_q;
    assign beat_cnt_o  = beat_cnt_q;

endmodule

// File: tb/tb_adma_wb_mem_slave.sv
module tb_adma_wb_mem_slave;

    localparam int          AW   = 10;
    localparam int          WS   = 2;
    localparam logic [31:0] BASE = 32'h0;

    logic        clk = 1'b0;
    logic        rst;
    logic        wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_cab_i;
    logic [31:0] wbs_adr_i;
    logic [7:0]  wbs_sel_i;
    logic [31:0] wbs_dat_i, wbs_dat64_i;
    logic [31:0] wbs_dat_o, wbs_dat64_o;
    logic        wbs_ack_o, wbs_err_o, wbs_rty_o;
    logic        mem_busy_i;
    logic [15:0] beat_cnt_o;

    always #5 clk = ~clk;

    adma_wb_mem_slave #(.AW(AW), .WAIT_STATES(WS), .BASE(BASE)) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .wbs_cyc_i   (wbs_cyc_i),
        .wbs_stb_i   (wbs_stb_i),
        .wbs_we_i    (wbs_we_i),
        .wbs_cab_i   (wbs_cab_i),
        .wbs_adr_i   (wbs_adr_i),
        .wbs_sel_i   (wbs_sel_i),
        .wbs_dat_i   (wbs_dat_i),
        .wbs_dat64_i (wbs_dat64_i),
        .wbs_dat_o   (wbs_dat_o),
        .wbs_dat64_o (wbs_dat64_o),
        .wbs_ack_o   (wbs_ack_o),
        .wbs_err_o   (wbs_err_o),
        .wbs_rty_o   (wbs_rty_o),
        .mem_busy_i  (mem_busy_i),
        .beat_cnt_o  (beat_cnt_o)
    );

    int checks = 0;
    int errors = 0;

    // Model state: what the outputs must be in the current cycle.
    bit          chk_en = 1'b0;
    logic        exp_ack, exp_err, exp_rty;
    logic [63:0] exp_dat;
    logic [15:0] exp_cnt;
    logic [63:0] model_mem [0:1023];

    // Per-transaction observations used by the literal checks.
    logic [31:0] ack_mask, err_mask, rty_mask;
    logic [63:0] beat_dat [0:7];
    logic [63:0] wbuf [0:7];
    int          nbeat;
    int          xc;
    logic [15:0] cnt_gap, cnt_after;

    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if (wbs_ack_o !== exp_ack) begin
                errors++;
                $display("FAIL ack t=%0t got %b want %b", $time, wbs_ack_o, exp_ack);
            end
            checks++;
            if (wbs_err_o !== exp_err) begin
                errors++;
                $display("FAIL err t=%0t got %b want %b", $time, wbs_err_o, exp_err);
            end
            checks++;
            if (wbs_rty_o !== exp_rty) begin
                errors++;
                $display("FAIL rty t=%0t got %b want %b", $time, wbs_rty_o, exp_rty);
            end
            checks++;
            if ({wbs_dat64_o, wbs_dat_o} !== exp_dat) begin
                errors++;
                $display("FAIL rdata t=%0t got %h want %h", $time, {wbs_dat64_o, wbs_dat_o}, exp_dat);
            end
            checks++;
            if (beat_cnt_o !== exp_cnt) begin
                errors++;
                $display("FAIL beat_cnt t=%0t got %0d want %0d", $time, beat_cnt_o, exp_cnt);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog t=%0t got running want finished", $time);
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    function automatic bit legal(input logic [31:0] a);
        return (a[2:0] == 3'b000) && (a >= BASE) && ((a - BASE) < 32'h2000);
    endfunction

    task automatic set_exp(input logic a, input logic e, input logic r);
        exp_ack = a;
        exp_err = e;
        exp_rty = r;
    endtask

    // Record what this cycle shows, then move to the next cycle.
    task automatic step();
        if (wbs_ack_o) ack_mask |= (32'd1 << xc);
        if (wbs_err_o) err_mask |= (32'd1 << xc);
        if (wbs_rty_o) rty_mask |= (32'd1 << xc);
        if (wbs_ack_o && nbeat < 8) begin
            beat_dat[nbeat] = {wbs_dat64_o, wbs_dat_o};
            nbeat++;
        end
        @(posedge clk);
        #1;
        xc++;
    endtask

    task automatic clear_obs();
        ack_mask = 0;
        err_mask = 0;
        rty_mask = 0;
        nbeat    = 0;
        xc       = 0;
    endtask

    task automatic model_write(input logic [31:0] a, input logic [7:0] sel, input logic [63:0] d);
        for (int b = 0; b < 8; b++) begin
            if (sel[b]) model_mem[a[AW+2:3]][b*8 +: 8] = d[b*8 +: 8];
        end
    endtask

    task automatic lit(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    // n-beat access starting at adr0; cab stays high until the last beat
    // is presented. Master releases the bus right after the terminating edge.
    task automatic xfer(input bit we, input logic [31:0] adr0, input int n,
                        input logic [7:0] sel, input bit busy);
        logic [31:0] a;
        int k;
        clear_obs();
        a           = adr0;
        wbs_cyc_i   = 1'b1;
        wbs_stb_i   = 1'b1;
        wbs_we_i    = we;
        wbs_cab_i   = (n > 1);
        wbs_adr_i   = a;
        wbs_sel_i   = sel;
        {wbs_dat64_i, wbs_dat_i} = wbuf[0];
        mem_busy_i  = busy;
        set_exp(0, 0, 0);
        step();
        mem_busy_i  = 1'b0;
        if (!legal(a) || busy) begin
            set_exp(0, !legal(a), legal(a));
            step();
        end else begin
            for (int c = 1; c <= WS; c++) begin
                set_exp(0, 0, 0);
                step();
            end
            k = 0;
            while (1'b1) begin
                set_exp(1, 0, 0);
                if (!we) exp_dat = model_mem[a[AW+2:3]];
                step();
                if (we) model_write(a, sel, wbuf[k]);
                if (exp_cnt != 16'hFFFF) exp_cnt++;
                k++;
                if (k == n) break;
                a         = a + 32'd8;
                wbs_adr_i = a;
                wbs_cab_i = (k < n - 1);
                {wbs_dat64_i, wbs_dat_i} = wbuf[k];
                if (!legal(a)) begin
                    set_exp(0, 1, 0);
                    step();
                    break;
                end
            end
        end
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        wbs_cab_i = 1'b0;
        wbs_we_i  = 1'b0;
        set_exp(0, 0, 0);
        cnt_gap = beat_cnt_o;
        step();
        exp_cnt   = 16'd0;
        cnt_after = beat_cnt_o;
        step();
        $display("xfer we=%0d adr=%h n=%0d sel=%h busy=%0d acks=%h errs=%h rtys=%h cnt=%0d",
                 we, adr0, n, sel, busy, ack_mask, err_mask, rty_mask, cnt_gap);
    endtask

    task automatic wr1(input logic [31:0] a, input logic [7:0] sel, input logic [63:0] d);
        wbuf[0] = d;
        xfer(1'b1, a, 1, sel, 1'b0);
    endtask

    task automatic rd1(input logic [31:0] a);
        xfer(1'b0, a, 1, 8'hFF, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0; wbs_cab_i = 0;
        wbs_adr_i = 0; wbs_sel_i = 0; wbs_dat_i = 0; wbs_dat64_i = 0;
        mem_busy_i = 0;
        for (int i = 0; i < 1024; i++) model_mem[i] = 64'h0;
        @(posedge clk);
        #1;
        set_exp(0, 0, 0);
        exp_dat = 64'h0;
        exp_cnt = 16'd0;
        chk_en  = 1'b1;
        clear_obs();
        step();
        step();
        rst = 1'b0;
        step();
        $display("xfer reset done");

        // Preload 0x8 for the reset-abort test.
        wr1(32'h8, 8'hFF, 64'hA5A50008_5A5A0008);

        // Single write then read back.
        wr1(32'h18, 8'hFF, 64'h00000300_00000200);
        lit("wr18_ack_cycle", {32'h0, ack_mask}, 64'h8);
        rd1(32'h18);
        lit("rd18_data", beat_dat[0], 64'h00000300_00000200);
        lit("rd18_ack_cycle", {32'h0, ack_mask}, 64'h8);
        lit("rd18_cnt_before_drop", {48'h0, cnt_gap}, 64'd1);
        lit("rd18_cnt_after_drop", {48'h0, cnt_after}, 64'd0);

        // Preload 0x280..0x298 with a write burst, then read it back as a burst.
        for (int k = 0; k < 4; k++) wbuf[k] = {32'h1000 + k, 32'h50 + k};
        xfer(1'b1, 32'h280, 4, 8'hFF, 1'b0);
        xfer(1'b0, 32'h280, 4, 8'hFF, 1'b0);
        lit("burst_ack_cycles", {32'h0, ack_mask}, 64'h78);
        for (int k = 0; k < 4; k++) lit("burst_beat_lo", {32'h0, beat_dat[k][31:0]}, 64'h50 + k);
        lit("burst_cnt", {48'h0, cnt_gap}, 64'd4);

        // Byte lanes.
        wr1(32'h40, 8'hFF, 64'hFFFFFFFF_FFFFFFFF);
        wr1(32'h40, 8'h0F, 64'h0);
        rd1(32'h40);
        lit("lane_rd40", beat_dat[0], 64'hFFFFFFFF_00000000);

        // Illegal addresses.
        wr1(32'h44, 8'hFF, 64'h0);
        lit("misalign_err", {32'h0, err_mask}, 64'h2);
        lit("misalign_noack", {32'h0, ack_mask}, 64'h0);
        rd1(32'h40);
        lit("misalign_ram_kept", beat_dat[0], 64'hFFFFFFFF_00000000);
        rd1(BASE + 32'h2000);
        lit("oob_err", {32'h0, err_mask}, 64'h2);

        // Busy -> retry, nothing written.
        wbuf[0] = 64'h0;
        xfer(1'b1, 32'h18, 1, 8'hFF, 1'b1);
        lit("busy_rty", {32'h0, rty_mask}, 64'h2);
        lit("busy_noerr", {32'h0, err_mask | ack_mask}, 64'h0);
        rd1(32'h18);
        lit("busy_ram_kept", beat_dat[0], 64'h00000300_00000200);

        // Strobe dropped during WAIT.
        clear_obs();
        wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 1; wbs_adr_i = 32'h18;
        wbs_sel_i = 8'hFF; {wbs_dat64_i, wbs_dat_i} = 64'h0;
        set_exp(0, 0, 0);
        step();
        step();
        wbs_stb_i = 0;
        step();
        step();
        wbs_cyc_i = 0; wbs_we_i = 0;
        step();
        step();
        $display("xfer abort adr=00000018 acks=%h errs=%h rtys=%h", ack_mask, err_mask, rty_mask);
        lit("abort_silent", {32'h0, ack_mask | err_mask | rty_mask}, 64'h0);
        rd1(32'h18);
        lit("abort_ram_kept", beat_dat[0], 64'h00000300_00000200);

        // sel = 0 write: acked, RAM unchanged.
        wr1(32'h18, 8'h00, 64'h0);
        lit("sel0_ack", {32'h0, ack_mask}, 64'h8);
        rd1(32'h18);
        lit("sel0_ram_kept", beat_dat[0], 64'h00000300_00000200);

        // Reset during WAIT of a write to 0x8.
        clear_obs();
        wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 1; wbs_adr_i = 32'h8;
        wbs_sel_i = 8'hFF; {wbs_dat64_i, wbs_dat_i} = 64'h0;
        set_exp(0, 0, 0);
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0;
        exp_dat = 64'h0;
        exp_cnt = 16'd0;
        step();
        step();
        $display("xfer reset-abort adr=00000008 acks=%h", ack_mask);
        lit("rst_noack", {32'h0, ack_mask}, 64'h0);
        rd1(32'h8);
        lit("rst_ram_kept", beat_dat[0], 64'hA5A50008_5A5A0008);

        // Burst running off the top of the window.
        wr1(32'h1FF8, 8'hFF, 64'h12345678_9ABCDEF0);
        xfer(1'b0, 32'h1FF8, 2, 8'hFF, 1'b0);
        lit("wrap_ack", {32'h0, ack_mask}, 64'h8);
        lit("wrap_err", {32'h0, err_mask}, 64'h10);
        lit("wrap_data", beat_dat[0], 64'h12345678_9ABCDEF0);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
